// File: rtl/clock_unit_counter.sv
// Modulo up/down time-unit counter with an up-prescaler, a BCD mirror of the count,
// and same-cycle carry/borrow so the next unit can step on the same edge as this one wraps.
module clock_unit_counter #(
  parameter int MODULO = 60,
  parameter int DIV    = 1,
  parameter int W      = 7
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_up,
  input  logic         i_down,
  output logic [W-1:0] o_count,
  output logic [3:0]   o_tens,
  output logic [3:0]   o_ones,
  output logic         o_carryup,
  output logic         o_borrowdown
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  MAXC    = W'(MODULO - 1);
  localparam logic [3:0]    MAX_T   = 4'((MODULO - 1) / 10);
  localparam logic [3:0]    MAX_O   = 4'((MODULO - 1) % 10);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [W-1:0]  count;
  logic [3:0]    tens, ones;

  logic up_only, dn_only, pre_full, at_max, at_zero;

  assign up_only  = i_up & ~i_down;
  assign dn_only  = i_down & ~i_up;
  assign pre_full = (pre == PRE_MAX);
  // >= so a forced out-of-range count wraps to 0 on the next increment
  assign at_max   = (count >= MAXC);
  assign at_zero  = (count == '0);

  // Gated by reset so a held reset never leaks a strobe into the next unit
  assign o_carryup    = i_rstn & up_only & pre_full & at_max;
  assign o_borrowdown = i_rstn & dn_only & at_zero;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pre   <= '0;
      count <= '0;
      tens  <= '0;
      ones  <= '0;
    end else if (i_up && i_down) begin
      pre   <= '0;
      count <= '0;
      tens  <= '0;
      ones  <= '0;
    end else if (up_only) begin
      if (!pre_full) begin
        pre <= pre + 1'b1;
      end else begin
        pre <= '0;
        if (at_max) begin
          count <= '0;
          tens  <= '0;
          ones  <= '0;
        end else begin
          count <= count + 1'b1;
          if (ones == 4'd9) begin
            ones <= '0;
            tens <= tens + 1'b1;
          end else begin
            ones <= ones + 1'b1;
          end
        end
      end
    end else if (dn_only) begin
      // Decrement is never prescaled and drops any partial up-count
      pre <= '0;
      if (at_zero) begin
        count <= MAXC;
        tens  <= MAX_T;
        ones  <= MAX_O;
      end else begin
        count <= count - 1'b1;
        if (ones == 4'd0) begin
          ones <= 4'd9;
          tens <= tens - 1'b1;
        end else begin
          ones <= ones - 1'b1;
        end
      end
    end
  end

  assign o_count = count;
  assign o_tens  = tens;
  assign o_ones  = ones;

endmodule

// File: tb/tb_clock_unit_counter.sv
// Drives sec-like (60/1), hr-like (24/1) and ms-like (100/10) units from one shared
// stimulus stream and compares every cycle against an arithmetic reference model.
module tb_clock_unit_counter;

  logic i_clk = 1'b0;
  logic i_rstn, i_up, i_down;

  logic [6:0] cnt_o  [3];
  logic [3:0] tens_o [3];
  logic [3:0] ones_o [3];
  logic       cy_o   [3];
  logic       bd_o   [3];

  always #5 i_clk = ~i_clk;

  clock_unit_counter #(.MODULO(60), .DIV(1), .W(7)) u_sec (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_up(i_up), .i_down(i_down),
    .o_count(cnt_o[0]), .o_tens(tens_o[0]), .o_ones(ones_o[0]),
    .o_carryup(cy_o[0]), .o_borrowdown(bd_o[0]));

  clock_unit_counter #(.MODULO(24), .DIV(1), .W(7)) u_hr (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_up(i_up), .i_down(i_down),
    .o_count(cnt_o[1]), .o_tens(tens_o[1]), .o_ones(ones_o[1]),
    .o_carryup(cy_o[1]), .o_borrowdown(bd_o[1]));

  clock_unit_counter #(.MODULO(100), .DIV(10), .W(7)) u_ms (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_up(i_up), .i_down(i_down),
    .o_count(cnt_o[2]), .o_tens(tens_o[2]), .o_ones(ones_o[2]),
    .o_carryup(cy_o[2]), .o_borrowdown(bd_o[2]));

  // Reference model: plain integers per unit
  int m_mod [3] = '{60, 24, 100};
  int m_div [3] = '{1, 1, 10};
  int m_cnt [3];
  int m_pre [3];

  int vectors = 0;
  int miscompares = 0;
  int cy_seen, cy_at;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_pre[k] = 0;
    end
  endtask

  task automatic model_edge(input logic u, input logic d);
    for (int k = 0; k < 3; k++) begin
      if (u && d) begin
        m_cnt[k] = 0;
        m_pre[k] = 0;
      end else if (u) begin
        if (m_pre[k] == m_div[k] - 1) begin
          m_pre[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
        end else begin
          m_pre[k] = m_pre[k] + 1;
        end
      end else if (d) begin
        m_pre[k] = 0;
        m_cnt[k] = (m_cnt[k] + m_mod[k] - 1) % m_mod[k];
      end
    end
  endtask

  task automatic check_all();
    int ecy, ebd;
    for (int k = 0; k < 3; k++) begin
      ecy = (i_rstn && i_up && !i_down && m_pre[k] == m_div[k] - 1 &&
             m_cnt[k] == m_mod[k] - 1) ? 1 : 0;
      ebd = (i_rstn && i_down && !i_up && m_cnt[k] == 0) ? 1 : 0;
      chk($sformatf("u%0d.count", k), int'(cnt_o[k]), m_cnt[k]);
      chk($sformatf("u%0d.tens", k), int'(tens_o[k]), m_cnt[k] / 10);
      chk($sformatf("u%0d.ones", k), int'(ones_o[k]), m_cnt[k] % 10);
      chk($sformatf("u%0d.carry", k), int'(cy_o[k]), ecy);
      chk($sformatf("u%0d.borrow", k), int'(bd_o[k]), ebd);
    end
  endtask

  // Called just after a negedge: drive, check comb outputs, take the edge
  task automatic step(input logic u, input logic d);
    i_up = u;
    i_down = d;
    #1;
    check_all();
    if (cy_o[2]) begin
      cy_seen++;
      cy_at = 0;
    end
    @(posedge i_clk);
    if (i_rstn) model_edge(u, d);
    @(negedge i_clk);
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    i_rstn = 1'b0;
    i_up = 1'b0;
    i_down = 1'b0;
    model_reset();
    @(negedge i_clk);
    // Reset held: state zero, no strobes even with requests present
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    i_rstn = 1'b1;

    // Full wrap of the 60-unit
    ups(59);
    chk("t1.pre_wrap_tens", int'(tens_o[0]), 5);
    chk("t1.pre_wrap_ones", int'(ones_o[0]), 9);
    step(1'b1, 1'b0);
    chk("t1.wrap_count", int'(cnt_o[0]), 0);

    // Borrow on the 24-unit
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("t2.hr_count", int'(cnt_o[1]), 23);
    chk("t2.hr_tens", int'(tens_o[1]), 2);
    chk("t2.hr_ones", int'(ones_o[1]), 3);

    // 1000 ups on the 100/10 unit: one carry, in the 1000th clock
    step(1'b1, 1'b1);
    cy_seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(1'b1, 1'b0);
      if (cy_seen == 1 && cy_at == 0) cy_at = i;
    end
    chk("t3.carry_pulses", cy_seen, 1);
    chk("t3.carry_clock", cy_at, 1000);
    chk("t3.final_count", int'(cnt_o[2]), 0);

    // Clear from 37, then borrow to 59
    step(1'b1, 1'b1);
    ups(37);
    chk("t4.at37", int'(cnt_o[0]), 37);
    step(1'b1, 1'b1);
    chk("t4.clr_count", int'(cnt_o[0]), 0);
    chk("t4.clr_ones", int'(ones_o[0]), 0);
    step(1'b0, 1'b1);
    chk("t4.borrow_count", int'(cnt_o[0]), 59);

    // Decrement discards a partial prescale
    step(1'b1, 1'b1);
    ups(7);
    step(1'b0, 1'b1);
    chk("t5.dec_count", int'(cnt_o[2]), 99);
    ups(9);
    chk("t5.nine_ups", int'(cnt_o[2]), 99);
    ups(1);
    chk("t5.tenth_up", int'(cnt_o[2]), 0);

    // Asynchronous reset mid-cycle at count 42
    step(1'b1, 1'b1);
    ups(42);
    chk("t6.at42", int'(cnt_o[0]), 42);
    i_up = 1'b0;
    i_down = 1'b0;
    #2;
    i_rstn = 1'b0;
    model_reset();
    #1;
    chk("t6.async_count", int'(cnt_o[0]), 0);
    chk("t6.async_tens", int'(tens_o[0]), 0);
    chk("t6.async_ones", int'(ones_o[0]), 0);
    chk("t6.async_ms", int'(cnt_o[2]), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    ups(9);
    chk("t6.ms_after_9", int'(cnt_o[2]), 0);
    ups(1);
    chk("t6.ms_after_10", int'(cnt_o[2]), 1);

    // Random mix of up, down, clear and idle
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 55, r >= 50 && r < 75);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
